bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_disp_pkg.sv | 8 +
 rtl/bcd_digit_step.sv | 15 +
 rtl/bcd_scan_counter.sv | 78 +++++++
 tb/tb_bcd_scan_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared digit count, BCD digit type and display helpers for the BCD scan counter.
package bcd_disp_pkg;
  localparam int NUM_DIGITS = 4;
  typedef logic [3:0] bcd_t;
  function automatic logic [1:0] msd_idx(input logic [15:0] c);
    return (c[15:12] != 4'd0) ? 2'd3 : (c[11:8] != 4'd0) ? 2'd2 : (c[7:4] != 4'd0) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit increment/decrement with carry/borrow in and out.
module bcd_digit_step
  import bcd_disp_pkg::*;
(
  input  bcd_t i_d,
  input  logic i_up,
  input  logic i_cin,
  output bcd_t o_q,
  output logic o_cout
);
  always_comb begin
    o_cout = i_cin & (i_up ? (i_d == 4'd9) : (i_d == 4'd0));
    o_q    = !i_cin ? i_d : o_cout ? (i_up ? 4'd0 : 4'd9) : i_up ? i_d + 4'd1 : i_d - 4'd1;
  end
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: prescaled 4-digit BCD up/down counter with multiplexed, leading-zero-blanked digit scan.
module bcd_scan_counter
  import bcd_disp_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] count,
  output logic [3:0]  bcd,
  output logic [3:0]  digit_sel,
  output logic        wrap
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_TERM = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_TERM = SW'(SCAN_DIV - 1);
  logic [PW-1:0]         r_pre;
  logic [SW-1:0]         r_scan;
  logic [1:0]            r_idx;
  logic [15:0]           r_count;
  logic [3:0]            r_bcd;
  logic [3:0]            r_sel;
  logic                  r_wrap;
  logic [15:0]           w_next;
  logic [NUM_DIGITS:0]   w_c;
  logic                  w_tick;
  logic                  w_blank;
  assign w_c[0] = 1'b1;
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit_step u_step (
        .i_d   (r_count[4*g +: 4]),
        .i_up  (up),
        .i_cin (w_c[g]),
        .o_q   (w_next[4*g +: 4]),
        .o_cout(w_c[g+1])
      );
    end
  endgenerate
  assign w_tick  = en && (r_pre == P_TERM);
  assign w_blank = (BLANK != 0) && (r_idx > msd_idx(r_count));
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pre   <= '0;
      r_count <= 16'h0000;
      r_wrap  <= 1'b0;
    end else begin
      if (en) r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) r_count <= w_next;
      r_wrap <= w_tick & w_c[NUM_DIGITS];
    end
  end
  // Outputs are registered from the current slot so bcd and digit_sel switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
      r_bcd  <= 4'h0;
      r_sel  <= 4'b1110;
    end else begin
      r_scan <= (r_scan == S_TERM) ? '0 : r_scan + SW'(1);
      if (r_scan == S_TERM) r_idx <= r_idx + 2'd1;
      r_bcd  <= r_count[{r_idx, 2'b00} +: 4];
      r_sel  <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
    end
  end
  assign count     = r_count;
  assign bcd       = r_bcd;
  assign digit_sel = r_sel;
  assign wrap      = r_wrap;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed self-checking bench for bcd_scan_counter (TICK_DIV=4, SCAN_DIV=2, BLANK=1).
module tb_bcd_scan_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        up  = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] count;
  logic [3:0]  bcd;
  logic [3:0]  digit_sel;
  logic        wrap;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;

  bcd_scan_counter #(.TICK_DIV(4), .SCAN_DIV(2), .BLANK(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .count    (count),
    .bcd      (bcd),
    .digit_sel(digit_sel),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
    step(1);
    rst = 1'b0;
    cyc = 0;
  endtask

  // After edge k the outputs show the slot the index held after edge k-1; the index advances every 2 edges.
  function automatic int slot_of(input int k);
    return (k < 1) ? 0 : ((k - 1) / 2) % 4;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [15:0] c, input int k);
    int s = slot_of(k);
    int m = (c[15:12] != 0) ? 3 : (c[11:8] != 0) ? 2 : (c[7:4] != 0) ? 1 : 0;
    return (s > m) ? 4'b1111 : ~(4'b0001 << s);
  endfunction

  function automatic logic [3:0] exp_bcd(input logic [15:0] c, input int k);
    logic [15:0] t = c >> (4 * slot_of(k));
    return t[3:0];
  endfunction

  task automatic test_reset;
    do_reset;
    en = 1'b1; up = 1'b1;
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0; en = 1'b0; cyc = 0;
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h exp 0000", count); end
    n_chk++; if (digit_sel !== 4'b1110) begin n_fail++; $display("FAIL reset_sel got %b exp 1110", digit_sel); end
    n_chk++; if (bcd !== 4'h0) begin n_fail++; $display("FAIL reset_bcd got %h exp 0", bcd); end
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", wrap); end
  endtask

  task automatic test_up_count;
    do_reset;
    en = 1'b1; up = 1'b1;
    step(36);
    n_chk++; if (count !== 16'h0009) begin n_fail++; $display("FAIL up_9 got %h exp 0009", count); end
    step(3);
    n_chk++; if (count !== 16'h0009) begin n_fail++; $display("FAIL up_pre_tick got %h exp 0009", count); end
    step(1);
    n_chk++; if (count !== 16'h0010) begin n_fail++; $display("FAIL up_carry got %h exp 0010", count); end
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_nowrap got %b exp 0", wrap); end
    up = 1'b0;
    step(4);
    n_chk++; if (count !== 16'h0009) begin n_fail++; $display("FAIL down_borrow got %h exp 0009", count); end
  endtask

  task automatic test_wrap;
    do_reset;
    en = 1'b1; up = 1'b1;
    step(39996);
    n_chk++; if (count !== 16'h9999 || wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_9999 got %h/%b exp 9999/0", count, wrap); end
    step(3);
    n_chk++; if (count !== 16'h9999) begin n_fail++; $display("FAIL wrap_hold got %h exp 9999", count); end
    step(1);
    n_chk++; if (count !== 16'h0000 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_up got %h/%b exp 0000/1", count, wrap); end
    step(1);
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_up_pulse got %b exp 0", wrap); end
    clr = 1'b1;
    step(1);
    clr = 1'b0; up = 1'b0;
    step(4);
    n_chk++; if (count !== 16'h9999 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_down got %h/%b exp 9999/1", count, wrap); end
    step(1);
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_down_pulse got %b exp 0", wrap); end
    step(3);
    n_chk++; if (count !== 16'h9998) begin n_fail++; $display("FAIL down_9998 got %h exp 9998", count); end
  endtask

  task automatic test_clr_collision;
    do_reset;
    en = 1'b1; up = 1'b1;
    step(168);
    n_chk++; if (count !== 16'h0042) begin n_fail++; $display("FAIL clr_pre42 got %h exp 0042", count); end
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n_chk++; if (count !== 16'h0000 || wrap !== 1'b0) begin n_fail++; $display("FAIL clr_tick got %h/%b exp 0000/0", count, wrap); end
    step(3);
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL clr_hold got %h exp 0000", count); end
    step(1);
    n_chk++; if (count !== 16'h0001) begin n_fail++; $display("FAIL clr_first got %h exp 0001", count); end
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL clr_mid got %h exp 0000", count); end
    step(3);
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL clr_pre_restart got %h exp 0000", count); end
    step(1);
    n_chk++; if (count !== 16'h0001) begin n_fail++; $display("FAIL clr_pre_restart1 got %h exp 0001", count); end
  endtask

  task automatic test_scan;
    do_reset;
    en = 1'b1; up = 1'b1;
    step(168);
    en = 1'b0;
    step(2);
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_chk++;
      if (digit_sel !== exp_sel(16'h0042, cyc) || bcd !== exp_bcd(16'h0042, cyc)) begin
        n_fail++;
        $display("FAIL scan42 cyc %0d got %b/%h exp %b/%h", cyc, digit_sel, bcd, exp_sel(16'h0042, cyc), exp_bcd(16'h0042, cyc));
      end
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_chk++;
      if (digit_sel !== ((slot_of(cyc) == 0) ? 4'b1110 : 4'b1111) || bcd !== 4'h0) begin
        n_fail++;
        $display("FAIL scan0 cyc %0d got %b/%h exp %b/0", cyc, digit_sel, bcd, (slot_of(cyc) == 0) ? 4'b1110 : 4'b1111);
      end
    end
  endtask

  task automatic test_hold;
    do_reset;
    en = 1'b1; up = 1'b1;
    step(170);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_chk++;
      if (count !== 16'h0042 || digit_sel !== exp_sel(16'h0042, cyc)) begin
        n_fail++;
        $display("FAIL hold cyc %0d got %h/%b exp 0042/%b", cyc, count, digit_sel, exp_sel(16'h0042, cyc));
      end
    end
    en = 1'b1;
    step(1);
    n_chk++; if (count !== 16'h0042) begin n_fail++; $display("FAIL hold_resume1 got %h exp 0042", count); end
    step(1);
    n_chk++; if (count !== 16'h0043) begin n_fail++; $display("FAIL hold_resume2 got %h exp 0043", count); end
  endtask

  initial begin
    test_reset;
    test_up_count;
    test_wrap;
    test_clr_collision;
    test_scan;
    test_hold;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
